// File: rtl/pixel_pkg.sv
// Shared types for the pixel clip/buffer stage.
//   pixel_t       : one plotted pixel (x, y, colour)
//   drain_state_t : done re-timing FSM states
package pixel_pkg;
   typedef struct packed {
      logic [7:0] x;
      logic [6:0] y;
      logic [2:0] colour;
   } pixel_t;

   localparam int SCREEN_W_DEF = 160;
   localparam int SCREEN_H_DEF = 120;
   localparam int PIX_W        = $bits(pixel_t);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_t;
endpackage

// File: rtl/pixel_clip_fifo_sync_fifo.sv
// First-word-fall-through FIFO with a registered head output.
//   clk, rst  : clock, async active-high reset
//   i_push    : write i_wdata (ignored when full)
//   i_pop     : consume head (ignored when empty)
//   o_rdata   : registered head entry, valid while !o_empty
//   o_full    : DEPTH entries held
//   o_empty   : no entries held
module sync_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr, r_rptr;
   logic [AW:0]      r_count;
   logic [WIDTH-1:0] r_head;

   logic             w_push, w_pop;
   logic [AW-1:0]    w_rptr_nxt;
   logic [AW:0]      w_count_nxt;

   assign o_full      = (r_count == (AW+1)'(DEPTH));
   assign o_empty     = (r_count == '0);
   assign w_push      = i_push && !o_full;
   assign w_pop       = i_pop && !o_empty;
   assign w_rptr_nxt  = r_rptr + AW'(w_pop);
   assign w_count_nxt = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
   assign o_rdata     = r_head;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= i_wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_head  <= '0;
      end else begin
         r_wptr  <= r_wptr + AW'(w_push);
         r_rptr  <= w_rptr_nxt;
         r_count <= w_count_nxt;
         // Preload the next head; a write landing on the new head slot
         // (FIFO empty after this pop) bypasses the memory.
         if (w_count_nxt != '0)
            r_head <= (w_push && (r_wptr == w_rptr_nxt)) ? i_wdata : r_mem[w_rptr_nxt];
      end
   end
endmodule

// File: rtl/pixel_clip_fifo.sv
// Clips off-screen pixels, buffers the rest, and re-times the engine's
// done level so o_drained means "every accepted pixel has left".
//   clk, rst              : clock, async active-high reset
//   i_in_valid/o_in_ready : pixel input handshake (i_in_x/y/colour)
//   i_in_done             : engine finished level
//   o_out_valid/i_out_ready : pixel output handshake (o_out_x/y/colour)
//   o_drained             : done towards LEDR[0]
//   o_clip_count          : saturating count of discarded pixels
module pixel_clip_fifo
   import pixel_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [7:0]  i_in_x,
   input  logic [6:0]  i_in_y,
   input  logic [2:0]  i_in_colour,
   input  logic        i_in_done,
   output logic        o_out_valid,
   input  logic        i_out_ready,
   output logic [7:0]  o_out_x,
   output logic [6:0]  o_out_y,
   output logic [2:0]  o_out_colour,
   output logic        o_drained,
   output logic [15:0] o_clip_count
);
   drain_state_t r_state, w_state_nxt;
   logic         r_done_q;
   logic [15:0]  r_clip_count;

   pixel_t w_wdata, w_head;
   logic   w_full, w_empty, w_accept, w_clip, w_leave_done;

   assign w_wdata      = '{x: i_in_x, y: i_in_y, colour: i_in_colour};
   assign o_in_ready   = !rst && !w_full;
   assign w_accept     = i_in_valid && o_in_ready;
   assign w_clip       = (32'(i_in_x) >= SCREEN_W) || (32'(i_in_y) >= SCREEN_H);
   assign w_leave_done = (r_state == DONE) && !i_in_done;

   sync_fifo #(.WIDTH(PIX_W), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_accept && !w_clip),
      .i_wdata (w_wdata),
      .i_pop   (i_out_ready),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign o_out_valid  = !w_empty;
   assign o_out_x      = w_head.x;
   assign o_out_y      = w_head.y;
   assign o_out_colour = w_head.colour;
   assign o_clip_count = r_clip_count;
   // In FLUSH the buffer-empty condition is already visible, so drained
   // goes high in the same cycle the FSM decides to enter DONE.
   assign o_drained    = (r_state == DONE) || ((r_state == FLUSH) && i_in_done && w_empty);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:  if (w_accept || (i_in_done && !r_done_q)) w_state_nxt = RUN;
         RUN:   if (i_in_done) w_state_nxt = FLUSH;
         FLUSH: begin
            if (!i_in_done)   w_state_nxt = IDLE;
            else if (w_empty) w_state_nxt = DONE;
         end
         DONE: begin
            if (!i_in_done)    w_state_nxt = IDLE;
            else if (w_accept) w_state_nxt = FLUSH;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_done_q     <= 1'b0;
         r_clip_count <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_done_q <= i_in_done;
         // Leaving DONE starts a new run, which outranks a same-cycle clip.
         if (w_leave_done)
            r_clip_count <= '0;
         else if (w_accept && w_clip && (r_clip_count != 16'hFFFF))
            r_clip_count <= r_clip_count + 16'd1;
      end
   end
endmodule
